// File: rtl/fir_mc.sv
// Multi-channel decimating FIR: one shared coefficient set and control FSM,
// with a private delay line and MAC for every channel lane.
module fir_mc #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIMATION = 2,
  parameter int FRAC_BITS  = 10,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] coeff = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           x_in_empty,
  output logic                           x_in_rd_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
  input  logic                           y_out_full,
  output logic                           y_out_wr_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] y_out,
  output logic                           busy
);
  // state | meaning
  // LOAD  | read DECIMATION words into the delay lines
  // MAC   | accumulate one tap per cycle, k = 0..TAPS-1
  // OUT   | hold y_out until the output FIFO accepts it
  typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

  localparam int K_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int D_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int P_W = 2 * DATA_WIDTH;
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);
  localparam logic [D_W-1:0] D_LAST = D_W'(DECIMATION - 1);

  state_t state, state_nxt;
  logic [K_W-1:0] k;
  logic [D_W-1:0] cnt;
  logic signed [DATA_WIDTH-1:0] x_dl    [CHANNELS][TAPS];
  logic signed [DATA_WIDTH-1:0] acc     [CHANNELS];
  logic signed [DATA_WIDTH-1:0] acc_nxt [CHANNELS];
  logic signed [P_W-1:0]        prod    [CHANNELS];
  logic signed [DATA_WIDTH-1:0] coef_k;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  // rd_en is gated by reset because LOAD is also the reset state
  always_comb begin
    state_nxt   = state;
    x_in_rd_en  = 1'b0;
    y_out_wr_en = 1'b0;
    busy        = 1'b0;
    case (state)
      LOAD: begin
        x_in_rd_en = reset && !x_in_empty;
        if (x_in_rd_en && cnt == D_LAST) state_nxt = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (k == K_LAST) state_nxt = OUT;
      end
      OUT: begin
        busy        = 1'b1;
        y_out_wr_en = !y_out_full;
        if (!y_out_full) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // full-width signed product, arithmetic shift, then wrap to DATA_WIDTH
  always_comb begin
    coef_k = $signed(coeff[K_LAST - k]);
    for (int c = 0; c < CHANNELS; c++) begin
      prod[c]    = P_W'(coef_k) * P_W'(x_dl[c][k]);
      acc_nxt[c] = acc[c] + DATA_WIDTH'(prod[c] >>> FRAC_BITS);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      k     <= '0;
      y_out <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        for (int j = 0; j < TAPS; j++) x_dl[c][j] <= '0;
      end
    end else begin
      if (x_in_rd_en) begin
        for (int c = 0; c < CHANNELS; c++) begin
          x_dl[c][0] <= x_in[c*DATA_WIDTH +: DATA_WIDTH];
          for (int j = 1; j < TAPS; j++) x_dl[c][j] <= x_dl[c][j-1];
        end
        if (cnt == D_LAST) begin
          cnt <= '0;
          k   <= '0;
          for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
        end else begin
          cnt <= cnt + D_W'(1);
        end
      end
      if (state == MAC) begin
        for (int c = 0; c < CHANNELS; c++) acc[c] <= acc_nxt[c];
        if (k == K_LAST) begin
          k <= '0;
          for (int c = 0; c < CHANNELS; c++) y_out[c*DATA_WIDTH +: DATA_WIDTH] <= acc_nxt[c];
        end else begin
          k <= k + K_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc: 2 lanes, 8 taps, decimate by 2, FRAC_BITS=2,
// checked against a direct convolution over the sample history plus hand-computed constants.
module tb_fir_mc;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int T  = 8;
  localparam int D  = 2;
  localparam int F  = 2;
  localparam logic [0:T-1][W-1:0] COEFF = {16'(3), 16'(-5), 16'(7), 16'(-11),
                                           16'(13), 16'(-17), 16'(19), 16'(-23)};

  logic clock;
  logic reset;
  logic x_in_empty;
  logic x_in_rd_en;
  logic [CH*W-1:0] x_in;
  logic y_out_full;
  logic y_out_wr_en;
  logic [CH*W-1:0] y_out;
  logic busy;

  fir_mc #(
    .CHANNELS(CH), .DATA_WIDTH(W), .TAPS(T), .DECIMATION(D), .FRAC_BITS(F), .coeff(COEFF)
  ) dut (
    .clock(clock), .reset(reset),
    .x_in_empty(x_in_empty), .x_in_rd_en(x_in_rd_en), .x_in(x_in),
    .y_out_full(y_out_full), .y_out_wr_en(y_out_wr_en), .y_out(y_out),
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic signed [W-1:0] y0, y1;
  assign y0 = y_out[W-1:0];
  assign y1 = y_out[2*W-1:W];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int nrd = 0;
  int nwr = 0;
  int last_rd_cyc = 0;
  bit starve = 1'b0;
  bit lat_chk = 1'b1;
  logic signed [W-1:0] hist0[$], hist1[$], exp0[$], exp1[$], wlog0[$], wlog1[$];

  task automatic chk(input string tag, input longint got, input longint expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // y[n] = sum_k wrap_W((coeff[T-1-k] * s[n-1-k]) >>> F), zero before the first sample
  function automatic logic signed [W-1:0] model(input int lane);
    logic signed [W-1:0] sum;
    longint s, p;
    int n;
    sum = '0;
    n = (lane == 0) ? hist0.size() : hist1.size();
    for (int k = 0; k < T; k++) begin
      s = 0;
      if (n - 1 - k >= 0) s = (lane == 0) ? hist0[n-1-k] : hist1[n-1-k];
      p = longint'($signed(COEFF[T-1-k])) * s;
      p = p >>> F;
      sum = sum + W'(p);
    end
    return sum;
  endfunction

  task automatic step(input logic empty, input logic full,
                      input logic signed [W-1:0] l0, input logic signed [W-1:0] l1,
                      output logic rd);
    @(negedge clock);
    x_in_empty = empty;
    y_out_full = full;
    x_in = {l1, l0};
    #1;
    cyc++;
    rd = x_in_rd_en;
    if (x_in_rd_en) begin
      chk("rd_while_empty", longint'(empty), 0);
      hist0.push_back(l0);
      hist1.push_back(l1);
      nrd++;
      if (nrd % D == 0) begin
        exp0.push_back(model(0));
        exp1.push_back(model(1));
        last_rd_cyc = cyc;
      end
    end
    if (y_out_wr_en) begin
      nwr++;
      wlog0.push_back(y0);
      wlog1.push_back(y1);
      chk("write_expected", longint'(exp0.size() > 0), 1);
      if (exp0.size() > 0) begin
        chk("y_lane0", y0, exp0.pop_front());
        chk("y_lane1", y1, exp1.pop_front());
      end
      if (lat_chk) chk("latency", cyc - last_rd_cyc, T + 1);
    end
  endtask

  task automatic feed(input logic signed [W-1:0] l0, input logic signed [W-1:0] l1);
    logic rd;
    int n;
    rd = 1'b0;
    n = 0;
    while (!rd && n < 100) begin
      step(starve ? logic'(cyc[0]) : 1'b0, 1'b0, l0, l1, rd);
      n++;
    end
    chk("feed_timeout", longint'(rd), 1);
  endtask

  task automatic drain();
    logic rd;
    int n;
    n = 0;
    while (exp0.size() != 0 && n < 200) begin
      step(1'b1, 1'b0, '0, '0, rd);
      n++;
    end
    chk("drain_timeout", exp0.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    x_in_empty = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_rd_en", x_in_rd_en, 0);
    chk("rst_wr_en", y_out_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y_out", y_out, 0);
    hist0.delete(); hist1.delete(); exp0.delete(); exp1.delete();
    nrd = 0;
    @(negedge clock);
    x_in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic impulse(input string tag);
    int imp_exp[8] = '{19, 13, 7, 3, 0, 0, 0, 0};
    wlog0.delete(); wlog1.delete();
    feed(16'sd4, 16'sd0);
    repeat (15) feed(16'sd0, 16'sd0);
    drain();
    chk({tag, "_count"}, wlog0.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog0.size()) begin
        chk({tag, "_lane0"}, wlog0[i], imp_exp[i]);
        chk({tag, "_lane1"}, wlog1[i], 0);
      end
    end
  endtask

  int v0[10] = '{32767, -32768, -1, 1, 12345, -7, 100, 32000, -32768, 3};
  int v1[10] = '{-32768, 32767, 1, -1, -23456, 5, -100, -3, 32767, -2};
  logic signed [W-1:0] ref0[$], ref1[$];
  logic signed [W-1:0] y_hold;
  logic rd_d;
  int w0;

  initial begin
    reset = 1'b0;
    x_in_empty = 1'b0;
    y_out_full = 1'b0;
    x_in = '0;
    #1;
    chk("init_rd_en", x_in_rd_en, 0);
    chk("init_wr_en", y_out_wr_en, 0);
    chk("init_busy", busy, 0);
    chk("init_y_out", y_out, 0);
    x_in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b1;

    impulse("impulse");

    wlog0.delete(); wlog1.delete();
    w0 = nwr;
    repeat (16) feed(16'sd4, 16'sd8);
    drain();
    chk("dc_count", nwr - w0, 8);
    if (wlog0.size() == 8) begin
      chk("dc_lane0_first_full", wlog0[3], -14);
      chk("dc_lane0_steady", wlog0[7], -14);
      chk("dc_lane1_steady", wlog1[7], -28);
    end

    do_reset();
    wlog0.delete(); wlog1.delete();
    for (int i = 0; i < 10; i++) feed(W'(v0[i]), W'(v1[i]));
    drain();
    ref0 = wlog0;
    ref1 = wlog1;

    do_reset();
    wlog0.delete(); wlog1.delete();
    starve = 1'b1;
    for (int i = 0; i < 10; i++) feed(W'(v0[i]), W'(v1[i]));
    drain();
    starve = 1'b0;
    chk("starve_count", wlog0.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog0.size() && i < ref0.size()) begin
        chk("starve_vs_plain_lane0", wlog0[i], ref0[i]);
        chk("starve_vs_plain_lane1", wlog1[i], ref1[i]);
      end
    end

    lat_chk = 1'b0;
    feed(16'sd100, -16'sd100);
    feed(16'sd50, 16'sd25);
    repeat (T + 1) step(1'b1, 1'b1, '0, '0, rd_d);
    y_hold = y0;
    chk("bp_busy", busy, 1);
    w0 = nwr;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 16'sd1, 16'sd1, rd_d);
      chk("bp_wr_en", y_out_wr_en, 0);
      chk("bp_rd_en", x_in_rd_en, 0);
      chk("bp_y_stable", y0, y_hold);
    end
    drain();
    chk("bp_one_write", nwr - w0, 1);
    lat_chk = 1'b1;

    feed(16'sd4, 16'sd4);
    feed(16'sd4, 16'sd4);
    repeat (5) step(1'b1, 1'b0, '0, '0, rd_d);
    chk("mac_busy", busy, 1);
    do_reset();
    w0 = nwr;
    repeat (20) step(1'b1, 1'b0, '0, '0, rd_d);
    chk("no_write_after_reset", nwr - w0, 0);
    impulse("impulse_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_mc.md
# fir_mc

Multi-channel, parametrised decimating FIR filter for the FM radio datapath. It is the successor to the single-channel `fir`. It filters `CHANNELS` independent sample streams, such as I/Q or L/R, that arrive packed in one FIFO word. All channels share one coefficient set and one control FSM, and every channel has its own delay line and MAC. It sits between FWFT FIFOs in the demodulator chain. It reads `DECIMATION` input words per output word and writes one packed output word per decimation period.

## Interface

Parameters:
- `CHANNELS`, 2: number of parallel channels per FIFO word (≥1).
- `DATA_WIDTH`, 32: signed sample/coefficient width per channel.
- `TAPS`, 32: filter length (≥2).
- `DECIMATION`, 2: input words consumed per output word (1..TAPS; 1 = no decimation).
- `FRAC_BITS`, 10: fixed-point dequantise shift applied to each product.
- `coeff`, all zero: `[0:TAPS-1][DATA_WIDTH-1:0]` signed coefficient array.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `x_in_empty`, in, 1: input FIFO empty.
- `x_in_rd_en`, out, 1: input FIFO read strobe.
- `x_in`, in, `CHANNELS*DATA_WIDTH`: FWFT input word; channel c is at `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `y_out_full`, in, 1: output FIFO full.
- `y_out_wr_en`, out, 1: output FIFO write strobe.
- `y_out`, out, `CHANNELS*DATA_WIDTH`: packed output word, same lane layout as `x_in`.
- `busy`, out, 1: high in MAC or OUT state.

## Operation

- FSM states: LOAD, MAC, OUT.
- **LOAD:** `x_in_rd_en = !x_in_empty` (combinational). On each read, every channel's delay line shifts one place, `x[c][j] <= x[c][j-1]`, and `x[c][0] <= x_in lane c`, so `x[c][0]` is the newest sample. The sample counter increments on each read. After the `DECIMATION`-th read, the counter clears and the FSM moves to MAC.
- **MAC:** the tap index k runs 0..TAPS-1, one tap per cycle. For each channel, `acc[c] += (coeff[TAPS-1-k] * x[c][k]) >>> FRAC_BITS`.
  - The product is full `2*DATA_WIDTH`.
  - The shift is arithmetic, truncating toward −∞.
  - The shifted result is truncated to `DATA_WIDTH` and accumulated with two's-complement wrap.
  - The accumulator clears when the FSM enters MAC.
  - After k = TAPS-1, the FSM registers `y_out <= acc` and moves to OUT.
- **OUT:** `y_out_wr_en = !y_out_full` (combinational). On the write cycle the FSM returns to LOAD. `y_out` holds its value until the next MAC completion.
- No input is read during MAC or OUT. The delay line is frozen outside LOAD.
- The delay line starts at zero, so the first output reflects zero history. This matches the golden C model.
- Channels never interact. Lane c's output depends only on lane c's inputs.

## Timing

- **Reset** (`reset` low, async): state = LOAD; counters, accumulators and delay lines = 0; `y_out` = 0. `x_in_rd_en`, `y_out_wr_en` and `busy` are 0 while reset is asserted.
- **Reset mid-operation:** a partial decimation group, an accumulation in progress, or a pending output is discarded. No write is issued after reset is released until a fresh group of `DECIMATION` reads completes.
- **Input handshake:** `x_in` is sampled in the same cycle as `x_in_rd_en` (FWFT). `x_in_empty` stalls LOAD without any state loss.
- **Output handshake:** `y_out` is valid whenever `y_out_wr_en` is high. `y_out_full` holds OUT indefinitely, and `y_out` stays stable during the stall.
- **Latency:** from the last read of a group to `y_out_wr_en` is TAPS+1 cycles when `y_out_full` is low.
- **Throughput:** DECIMATION + TAPS + 1 cycles per output when unstalled.
- **Simultaneous events:**
  - `x_in_empty` and `y_out_full` can never both matter in the same cycle, because LOAD and OUT are disjoint states.
  - A FIFO that deasserts `x_in_empty` in the same cycle `x_in_rd_en` would be evaluated is honoured combinationally.
- **Multiplier:** one `DATA_WIDTH`×`DATA_WIDTH` multiplier per channel.
- **Registers:** the accumulator feeds back through one register. No additional pipeline registers are required at the 10 ns target.

## Test plan

- **Impulse:** CHANNELS=2, TAPS=32, DECIMATION=1, FRAC_BITS=0. Lane 0 receives 1 followed by zeros; lane 1 receives all zeros. Required response: lane 0 outputs `coeff[31]`, `coeff[30]`, …, `coeff[0]`, then 0. Lane 1 is always 0.
- **Decimation and DC:** DECIMATION=2, all inputs 1024, FRAC_BITS=10. Required response: one output per 2 reads. The steady-state output equals the sum of `coeff`. Output count = floor(N/2).
- **Golden regression:** FM `x.txt` with the default parameters and a 32-tap coefficient set, applied per lane, with lanes fed different files. Required response: 0 mismatches against the C-model `cmp.txt` per lane.
- **Backpressure:** hold `y_out_full` high for 50 cycles while in OUT. Required response: `y_out_wr_en` = 0, `x_in_rd_en` = 0, `y_out` stable; exactly one write after release.
- **Starvation:** toggle `x_in_empty` every cycle. Required response: outputs bit-identical to the unstalled run, and each read coincides with `!x_in_empty`.
- **Reset mid-MAC:** assert reset at k = 10. Required response: outputs go to 0 immediately, no write follows, and after re-feeding the impulse the response matches the impulse scenario from its start.
